pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the vector ASIP. Drives the enable/flush controls of the IF, IF/ID, ID/EX and
//  EX/MEM registers. Resolves load-use hazards (1-cycle bubble) and taken branches (flush of the two
//  younger stages). Splits V-lane vector memory ops into BEAT-lane memory beats, freezing the pipe
//  until the last beat is accepted. Sits beside the pipeline registers; consumes ID and EX control fields.
// PARAMETERS
//  V     20  vector lanes per vector register
//  BEAT  4   lanes transferred per memory beat; NBEATS = ceil(V/BEAT) (5 by default), counter width
//            CW = max(1,$clog2(NBEATS))
// PORTS
//  CLK              in   1   clock, rising edge
//  RST              in   1   reset, asynchronous, active-low
//  ID_A1_i          in   5   source reg 1 of instruction in ID
//  ID_A2_i          in   5   source reg 2 of instruction in ID
//  ID_Uses1_i       in   1   ID instruction reads A1
//  ID_Uses2_i       in   1   ID instruction reads A2
//  EX_A3_i          in   5   destination reg of instruction in EX (ID/EX A3 output)
//  EX_RegFile_WE_i  in   1   EX instruction writes register file
//  EX_WBSelect_i    in   1   1 = EX instruction writes back memory data (load)
//  EX_MemWE_i       in   1   EX instruction is a store
//  EX_OpType_i      in   2   2'b10 = vector operation
//  BranchTaken_i    in   1   branch resolved taken in EX this cycle
//  MemReady_i       in   1   memory accepts current beat this cycle
//  En_IF_o          out  1   PC / fetch enable
//  En_IFID_o        out  1   IF/ID enable
//  En_IDEX_o        out  1   ID/EX enable (Pipe_ID_EX enable_i)
//  En_EXMEM_o       out  1   EX/MEM enable
//  Flush_IFID_o     out  1   load bubble into IF/ID
//  Flush_IDEX_o     out  1   load bubble into ID/EX
//  MemReq_o         out  1   vector beat request valid
//  VecBeat_o        out  CW  index of current beat; lanes [VecBeat*BEAT +: BEAT]
//  VecBusy_o        out  1   state == VEC
// BEHAVIOUR
//  State: RUN, VEC; beat counter cnt (CW bits). RST low -> RUN, cnt=0 immediately (async).
//  While RST low: all En_*=1, Flush_*=0, MemReq_o=0, VecBeat_o=0, VecBusy_o=0.
//  Derived: vmem = (EX_OpType_i==2'b10) & (EX_WBSelect_i | EX_MemWE_i);
//   luh = EX_WBSelect_i & EX_RegFile_WE_i & ((ID_Uses1_i & ID_A1_i==EX_A3_i) | (ID_Uses2_i & ID_A2_i==EX_A3_i)).
//  RUN, priority highest first (outputs combinational; default all En=1, Flush=0, MemReq=0):
//   1 vmem: setup cycle; all En=0; next state VEC, cnt<=0. BranchTaken_i ignored.
//   2 BranchTaken_i: Flush_IFID_o=1, Flush_IDEX_o=1, all En=1; luh ignored (younger instr discarded).
//   3 luh: En_IF=0, En_IFID=0, Flush_IDEX_o=1, En_IDEX=1, En_EXMEM=1 (one bubble); stays RUN.
//   4 else: pass-through.
//  VEC: MemReq_o=1, VecBeat_o=cnt, VecBusy_o=1.
//   MemReady_i=0: all En=0, hold cnt.
//   MemReady_i=1 & cnt<NBEATS-1: all En=0, cnt<=cnt+1.
//   MemReady_i=1 & cnt==NBEATS-1: all En=1 (vector op retires to MEM), cnt<=0, next RUN.
//   No flush in VEC; BranchTaken_i, luh ignored (pipe frozen, inputs stable).
//  Vector mem op cost: 1 setup + NBEATS accepted beats; minimum 1+NBEATS cycles.
//  Last beat partial when V%BEAT!=0 (default: none); lane masking is the memory side's job.
//  Reset mid-VEC: MemReq_o drops asynchronously; the in-flight beat is abandoned; no retry.
//  No self-loop hazard check on reg 0; A3==0 is compared like any register.
// TESTING
//  Load r3 in EX (WBSelect=1,WE=1,A3=3), ID reads A1=3 Uses1=1 -> 1 cycle: En_IF=En_IFID=0, Flush_IDEX=1; next cycle clean.
//  Same as above with Uses1=0 -> no stall; all En=1, Flush=0.
//  BranchTaken_i=1 with luh also true -> Flush_IFID=Flush_IDEX=1, all En=1, no stall.
//  Vector load, MemReady_i=1 constant -> 1 setup + beats 0..4; En=0 for 5 cycles, En=1 on beat 4; VecBusy high 5 cycles.
//  Vector store, MemReady_i low on beats 1 and 3 for 2 cycles each -> VecBeat holds; total 1+5+4=10 cycles frozen/in VEC.
//  RST low during beat 2 -> MemReq_o=0 and VecBeat_o=0 same cycle; after release RUN, all En=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline registers and the hazard sequencer.
// The pipeline side (master) supplies the ID/EX control fields and the memory
// handshake. The sequencer (slave) returns the stage enables, the flushes and
// the vector beat request.
interface pipe_hazard_ctrl_if #(
  parameter int V    = 20,
  parameter int BEAT = 4
);
  localparam int NBEATS = (V + BEAT - 1) / BEAT;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic [4:0]    ID_A1_i;
  logic [4:0]    ID_A2_i;
  logic          ID_Uses1_i;
  logic          ID_Uses2_i;
  logic [4:0]    EX_A3_i;
  logic          EX_RegFile_WE_i;
  logic          EX_WBSelect_i;
  logic          EX_MemWE_i;
  logic [1:0]    EX_OpType_i;
  logic          BranchTaken_i;
  logic          MemReady_i;

  logic          En_IF_o;
  logic          En_IFID_o;
  logic          En_IDEX_o;
  logic          En_EXMEM_o;
  logic          Flush_IFID_o;
  logic          Flush_IDEX_o;
  logic          MemReq_o;
  logic [CW-1:0] VecBeat_o;
  logic          VecBusy_o;

  modport master (
    output ID_A1_i, ID_A2_i, ID_Uses1_i, ID_Uses2_i, EX_A3_i, EX_RegFile_WE_i,
           EX_WBSelect_i, EX_MemWE_i, EX_OpType_i, BranchTaken_i, MemReady_i,
    input  En_IF_o, En_IFID_o, En_IDEX_o, En_EXMEM_o, Flush_IFID_o, Flush_IDEX_o,
           MemReq_o, VecBeat_o, VecBusy_o
  );

  modport slave (
    input  ID_A1_i, ID_A2_i, ID_Uses1_i, ID_Uses2_i, EX_A3_i, EX_RegFile_WE_i,
           EX_WBSelect_i, EX_MemWE_i, EX_OpType_i, BranchTaken_i, MemReady_i,
    output En_IF_o, En_IFID_o, En_IDEX_o, En_EXMEM_o, Flush_IFID_o, Flush_IDEX_o,
           MemReq_o, VecBeat_o, VecBusy_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the vector ASIP.
// Inserts a one-cycle bubble on load-use hazards and flushes the two younger
// stages on a taken branch. A vector memory op in EX is split into
// ceil(V/BEAT) memory beats while the whole pipe stays frozen. Stage controls
// are combinational so they act in the same cycle the hazard is seen.
module pipe_hazard_ctrl #(
  parameter int V    = 20,
  parameter int BEAT = 4
) (
  input logic              CLK,
  input logic              RST,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int NBEATS = (V + BEAT - 1) / BEAT;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  typedef enum logic {RUN, VEC} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          vmem;
  logic          luh;
  logic          last_accept;

  // Classify the EX instruction and detect a load feeding the ID instruction
  always_comb begin
    vmem = (bus.EX_OpType_i == 2'b10) & (bus.EX_WBSelect_i | bus.EX_MemWE_i);
    luh  = bus.EX_WBSelect_i & bus.EX_RegFile_WE_i &
           ((bus.ID_Uses1_i & (bus.ID_A1_i == bus.EX_A3_i)) |
            (bus.ID_Uses2_i & (bus.ID_A2_i == bus.EX_A3_i)));
    last_accept = bus.MemReady_i & (cnt == LAST_BEAT);
  end

  // Sequencer state: one setup cycle into VEC, then count accepted beats
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (vmem) begin
            state <= VEC;
            cnt   <= '0;
          end
        end
        VEC: begin
          if (last_accept) begin
            state <= RUN;
            cnt   <= '0;
          end else if (bus.MemReady_i) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Stage enables, flushes and beat request; reset forces a free-running pipe
  always_comb begin
    bus.En_IF_o      = 1'b1;
    bus.En_IFID_o    = 1'b1;
    bus.En_IDEX_o    = 1'b1;
    bus.En_EXMEM_o   = 1'b1;
    bus.Flush_IFID_o = 1'b0;
    bus.Flush_IDEX_o = 1'b0;
    bus.MemReq_o     = 1'b0;
    bus.VecBeat_o    = '0;
    bus.VecBusy_o    = 1'b0;
    if (RST) begin
      case (state)
        RUN: begin
          if (vmem) begin
            bus.En_IF_o    = 1'b0;
            bus.En_IFID_o  = 1'b0;
            bus.En_IDEX_o  = 1'b0;
            bus.En_EXMEM_o = 1'b0;
          end else if (bus.BranchTaken_i) begin
            bus.Flush_IFID_o = 1'b1;
            bus.Flush_IDEX_o = 1'b1;
          end else if (luh) begin
            bus.En_IF_o      = 1'b0;
            bus.En_IFID_o    = 1'b0;
            bus.Flush_IDEX_o = 1'b1;
          end
        end
        VEC: begin
          bus.MemReq_o  = 1'b1;
          bus.VecBeat_o = cnt;
          bus.VecBusy_o = 1'b1;
          if (!last_accept) begin
            bus.En_IF_o    = 1'b0;
            bus.En_IFID_o  = 1'b0;
            bus.En_IDEX_o  = 1'b0;
            bus.En_EXMEM_o = 1'b0;
          end
        end
        default: begin
          bus.En_IF_o = 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// A behavioural model (vector-op phase plus number of beats accepted so far)
// predicts every output each cycle; directed scenarios add literal checks.
module tb_pipe_hazard_ctrl;
  localparam int V      = 20;
  localparam int BEAT   = 4;
  localparam int NBEATS = (V + BEAT - 1) / BEAT;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  bit   cmpOn;

  bit   mInVec;
  int   mBeats;

  int   eEnIF, eEnIFID, eEnIDEX, eEnEXMEM, eFlIFID, eFlIDEX, eReq, eBeat, eBusy;

  pipe_hazard_ctrl_if #(.V(V), .BEAT(BEAT)) bus ();

  pipe_hazard_ctrl #(.V(V), .BEAT(BEAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one full set of pipeline inputs
  task automatic applyStimulus(input int a1, input int a2, input bit u1, input bit u2,
                               input int a3, input bit we, input bit wb, input bit mwe,
                               input int op, input bit br, input bit rdy);
    bus.ID_A1_i         = 5'(a1);
    bus.ID_A2_i         = 5'(a2);
    bus.ID_Uses1_i      = u1;
    bus.ID_Uses2_i      = u2;
    bus.EX_A3_i         = 5'(a3);
    bus.EX_RegFile_WE_i = we;
    bus.EX_WBSelect_i   = wb;
    bus.EX_MemWE_i      = mwe;
    bus.EX_OpType_i     = 2'(op);
    bus.BranchTaken_i   = br;
    bus.MemReady_i      = rdy;
  endtask

  // Single comparison with pass/fail bookkeeping
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  // Model: what the pipe must see, given the phase and the rules for hazards
  task automatic computeExpected();
    bit isVecMem;
    bit loadUse;
    isVecMem = (bus.EX_OpType_i == 2) && (bus.EX_WBSelect_i || bus.EX_MemWE_i);
    loadUse  = bus.EX_WBSelect_i && bus.EX_RegFile_WE_i &&
               ((bus.ID_Uses1_i && bus.ID_A1_i == bus.EX_A3_i) ||
                (bus.ID_Uses2_i && bus.ID_A2_i == bus.EX_A3_i));
    eEnIF = 1; eEnIFID = 1; eEnIDEX = 1; eEnEXMEM = 1;
    eFlIFID = 0; eFlIDEX = 0; eReq = 0; eBeat = 0; eBusy = 0;
    if (!RST) return;
    if (mInVec) begin
      eReq = 1; eBeat = mBeats; eBusy = 1;
      if (!(bus.MemReady_i && mBeats == NBEATS - 1)) begin
        eEnIF = 0; eEnIFID = 0; eEnIDEX = 0; eEnEXMEM = 0;
      end
    end else if (isVecMem) begin
      eEnIF = 0; eEnIFID = 0; eEnIDEX = 0; eEnEXMEM = 0;
    end else if (bus.BranchTaken_i) begin
      eFlIFID = 1; eFlIDEX = 1;
    end else if (loadUse) begin
      eEnIF = 0; eEnIFID = 0; eFlIDEX = 1;
    end
  endtask

  // Advance the model phase on every clock edge
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mInVec <= 1'b0;
      mBeats <= 0;
    end else if (mInVec) begin
      if (bus.MemReady_i) begin
        if (mBeats + 1 == NBEATS) begin
          mInVec <= 1'b0;
          mBeats <= 0;
        end else begin
          mBeats <= mBeats + 1;
        end
      end
    end else if ((bus.EX_OpType_i == 2) && (bus.EX_WBSelect_i || bus.EX_MemWE_i)) begin
      mInVec <= 1'b1;
      mBeats <= 0;
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge CLK) begin
    if (cmpOn) begin
      computeExpected();
      checkOutput("En_IF",      int'(bus.En_IF_o),      eEnIF);
      checkOutput("En_IFID",    int'(bus.En_IFID_o),    eEnIFID);
      checkOutput("En_IDEX",    int'(bus.En_IDEX_o),    eEnIDEX);
      checkOutput("En_EXMEM",   int'(bus.En_EXMEM_o),   eEnEXMEM);
      checkOutput("Flush_IFID", int'(bus.Flush_IFID_o), eFlIFID);
      checkOutput("Flush_IDEX", int'(bus.Flush_IDEX_o), eFlIDEX);
      checkOutput("MemReq",     int'(bus.MemReq_o),     eReq);
      checkOutput("VecBeat",    int'(bus.VecBeat_o),    eBeat);
      checkOutput("VecBusy",    int'(bus.VecBusy_o),    eBusy);
    end
  end

  // Run one vector memory op to retirement, stalling memory on chosen beats
  task automatic runVector(input bit isStore, input bit withHazards,
                           output int enLow, output int busyCyc, output int total,
                           output int setupFlush);
    int  stallCnt [NBEATS];
    bit  done;
    bit  rdy;
    for (int b = 0; b < NBEATS; b++) stallCnt[b] = 0;
    enLow = 0; busyCyc = 0; total = 0; setupFlush = 0; done = 0;
    applyStimulus(5, 0, withHazards, 0, 5, !isStore, !isStore, isStore, 2, withHazards, 1);
    for (int c = 0; c < 40 && !done; c++) begin
      rdy = 1'b1;
      if (mInVec && isStore && (mBeats == 1 || mBeats == 3) && stallCnt[mBeats] < 2) begin
        rdy = 1'b0;
        stallCnt[mBeats]++;
      end
      bus.MemReady_i = rdy;
      @(negedge CLK);
      if (c == 0) setupFlush = int'(bus.Flush_IFID_o) + int'(bus.Flush_IDEX_o);
      if (!bus.En_IF_o) enLow++;
      if (bus.VecBusy_o) busyCyc++;
      if (!bus.En_IF_o || bus.VecBusy_o) total++;
      if (bus.VecBusy_o && bus.En_EXMEM_o) done = 1'b1;
      nextCycle();
    end
    checkOutput("vec_retired", int'(done), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int  enLow, busyCyc, total, setupFlush;
    bit  found;
    checks = 0;
    errors = 0;
    cmpOn  = 1'b0;
    RST    = 1'b0;
    // Vector op presented during reset must not stall anything
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 1);
    #2;
    checkOutput("rst_En_IF",   int'(bus.En_IF_o),   1);
    checkOutput("rst_En_EXMEM", int'(bus.En_EXMEM_o), 1);
    checkOutput("rst_MemReq",  int'(bus.MemReq_o),  0);
    checkOutput("rst_VecBusy", int'(bus.VecBusy_o), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #10;
    RST   = 1'b1;
    cmpOn = 1'b1;
    nextCycle();

    // Load r3 in EX, ID reads r3 on A1: one bubble
    applyStimulus(3, 9, 1, 0, 3, 1, 1, 0, 0, 0, 1);
    @(negedge CLK);
    checkOutput("luh_En_IF",      int'(bus.En_IF_o),      0);
    checkOutput("luh_En_IFID",    int'(bus.En_IFID_o),    0);
    checkOutput("luh_En_IDEX",    int'(bus.En_IDEX_o),    1);
    checkOutput("luh_Flush_IDEX", int'(bus.Flush_IDEX_o), 1);
    nextCycle();
    applyStimulus(3, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge CLK);
    checkOutput("luh_after_En_IF",  int'(bus.En_IF_o),      1);
    checkOutput("luh_after_Flush",  int'(bus.Flush_IDEX_o), 0);
    nextCycle();

    // Same registers but A1 not read: no stall
    applyStimulus(3, 9, 0, 0, 3, 1, 1, 0, 0, 0, 1);
    @(negedge CLK);
    checkOutput("nouse_En_IF",      int'(bus.En_IF_o),      1);
    checkOutput("nouse_Flush_IDEX", int'(bus.Flush_IDEX_o), 0);
    nextCycle();

    // A2 path with register 0 is compared like any other
    applyStimulus(4, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    @(negedge CLK);
    checkOutput("r0_En_IFID", int'(bus.En_IFID_o), 0);
    nextCycle();

    // Taken branch beats load-use
    applyStimulus(3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 1);
    @(negedge CLK);
    checkOutput("br_Flush_IFID", int'(bus.Flush_IFID_o), 1);
    checkOutput("br_Flush_IDEX", int'(bus.Flush_IDEX_o), 1);
    checkOutput("br_En_IF",      int'(bus.En_IF_o),      1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    nextCycle();

    // Vector load, memory always ready, with branch and load-use also raised
    runVector(1'b0, 1'b1, enLow, busyCyc, total, setupFlush);
    checkOutput("vld_en_low_cycles", enLow, 5);
    checkOutput("vld_busy_cycles",   busyCyc, 5);
    checkOutput("vld_frozen_total",  total, 6);
    checkOutput("vld_setup_flush",   setupFlush, 0);
    nextCycle();

    // Vector store, memory stalls two cycles on beats 1 and 3
    runVector(1'b1, 1'b0, enLow, busyCyc, total, setupFlush);
    checkOutput("vst_en_low_cycles", enLow, 9);
    checkOutput("vst_busy_cycles",   busyCyc, 9);
    checkOutput("vst_frozen_total",  total, 10);
    nextCycle();

    // Reset arriving during beat 2 abandons the op immediately
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 2, 0, 1);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge CLK);
      if (bus.VecBusy_o && bus.VecBeat_o == 2) found = 1'b1;
      else nextCycle();
    end
    checkOutput("rstvec_reached_beat2", int'(found), 1);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("rstvec_MemReq",  int'(bus.MemReq_o),  0);
    checkOutput("rstvec_VecBeat", int'(bus.VecBeat_o), 0);
    checkOutput("rstvec_En_IF",   int'(bus.En_IF_o),   1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("post_rst_En_EXMEM", int'(bus.En_EXMEM_o), 1);
    checkOutput("post_rst_VecBusy",  int'(bus.VecBusy_o),  0);
    nextCycle();
    nextCycle();

    cmpOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end
endmodule
